flow_sequencer: RTL and testbench

Control sequencer directly upstream of `program_flow`. It generates the `cycle` phase signal and decodes the memory byte on `in_data` into the A-phase and B-phase control strobes for the two interleaved threads (T = 0, E = 1). It keeps one instruction state machine per thread, and each cycle it muxes its outputs by phase: A controls come from the A thread, B controls from the B thread.

---
 rtl/flow_pkg.sv | 58 +++++
 rtl/flow_sequencer_thread_fsm.sv | 130 +++++++++++++
 rtl/flow_sequencer.sv | 87 ++++++++
 tb/tb_flow_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/flow_pkg.sv
// ============================================================================
// Module   : flow_pkg
// Purpose  : Shared opcodes, FSM states, phase constants and control bundles
//            for the flow sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package flow_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_NOP  = 3'b000;
  localparam logic [OPW-1:0] OP_JST  = 3'b001;
  localparam logic [OPW-1:0] OP_JTR  = 3'b010;
  localparam logic [OPW-1:0] OP_BSTK = 3'b011;
  localparam logic [OPW-1:0] OP_CALL = 3'b100;
  localparam logic [OPW-1:0] OP_WR   = 3'b101;
  localparam logic [OPW-1:0] OP_HALT = 3'b110;

  localparam logic T    = 1'b0;
  localparam logic E    = 1'b1;
  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_OPC   = 2'd1,
    ST_OPR   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  typedef struct packed {
    logic en_pc;
    logic en_ra;
    logic en_addr_hi;
    logic en_addr_lo;
    logic mux_ra;
    logic mux_pc_a1;
    logic mux_pc_a2;
    logic mux_offs;
  } b_ctrl_t;

  typedef struct packed {
    logic [1:0] jc;
    logic       mem;
    logic [1:0] n;
  } a_ctrl_t;

  // Both 11x encodings collapse onto HALT so every byte decodes to a known op.
  function automatic logic [OPW-1:0] decode_op(input logic [7:0] byte_in);
    if (byte_in[7:6] == 2'b11) return OP_HALT;
    return byte_in[7:5];
  endfunction

endpackage

`default_nettype wire

// File: rtl/flow_sequencer_thread_fsm.sv
// ============================================================================
// Module   : thread_fsm
// Purpose  : Instruction state machine for one interleaved thread; produces
//            its B-phase strobes and the A-phase controls from its flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module thread_fsm
  import flow_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_b_active,
  input  logic [7:0] i_data,
  output logic [1:0] o_state,
  output b_ctrl_t    o_b,
  output a_ctrl_t    o_a
);

  state_e     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic       retire_q, retire_d;
  logic       wr_pend_q, wr_pend_d;
  logic       call_pend_q, call_pend_d;
  logic [OPW-1:0] w_op_in;
  logic [OPW-1:0] w_op_lat;
  logic       unused_op_bits;

  assign w_op_in        = decode_op(i_data);
  assign w_op_lat       = decode_op(op_q);
  assign unused_op_bits = ^op_q[3:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_START;
      op_q        <= '0;
      retire_q    <= 1'b0;
      wr_pend_q   <= 1'b0;
      call_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      retire_q    <= retire_d;
      wr_pend_q   <= wr_pend_d;
      call_pend_q <= call_pend_d;
    end
  end

  // Flags default to clear: set only by a B phase, consumed by the next A phase.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    retire_d    = 1'b0;
    wr_pend_d   = 1'b0;
    call_pend_d = 1'b0;
    o_b         = '0;
    case (state_q)
      ST_START: begin
        if (i_b_active) state_d = ST_OPC;
      end
      ST_OPC: begin
        if (w_op_in == OP_HALT) begin
          if (i_b_active) state_d = ST_HALT;
        end else if (w_op_in == OP_NOP || w_op_in == OP_WR) begin
          o_b.en_pc = 1'b1;
          if (i_b_active) begin
            retire_d  = 1'b1;
            wr_pend_d = (w_op_in == OP_WR);
          end
        end else begin
          o_b.en_pc = 1'b1;
          if (i_b_active) begin
            op_d    = i_data;
            state_d = ST_OPR;
          end
        end
      end
      ST_OPR: begin
        case (w_op_lat)
          OP_JST, OP_JTR: begin
            o_b.en_pc      = 1'b1;
            o_b.en_addr_hi = 1'b1;
            o_b.en_addr_lo = 1'b1;
            o_b.mux_pc_a2  = 1'b1;
            o_b.en_ra      = 1'b1;
            o_b.mux_offs   = (w_op_lat == OP_JST);
          end
          OP_BSTK: begin
            o_b.en_pc     = 1'b1;
            o_b.mux_pc_a1 = 1'b1;
            o_b.mux_pc_a2 = 1'b1;
            o_b.mux_offs  = op_q[4];
          end
          OP_CALL: begin
            o_b.en_pc    = 1'b1;
            o_b.en_ra    = 1'b1;
            o_b.mux_ra   = 1'b1;
            o_b.mux_offs = op_q[4];
            if (i_b_active) call_pend_d = 1'b1;
          end
          default: ;
        endcase
        if (i_b_active) begin
          retire_d = 1'b1;
          state_d  = ST_OPC;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    o_a.n   = op_q[1:0];
    o_a.mem = wr_pend_q;
    if (call_pend_q)
      o_a.jc = 2'b11;
    else if (state_q == ST_OPR && (w_op_lat == OP_JST || w_op_lat == OP_JTR))
      o_a.jc = 2'b10;
    else if (retire_q)
      o_a.jc = 2'b00;
    else
      o_a.jc = 2'b01;
  end

  assign o_state = state_q;

endmodule

`default_nettype wire

// File: rtl/flow_sequencer.sv
// ============================================================================
// Module   : flow_sequencer
// Purpose  : Phase generator and per-phase output mux for two interleaved
//            thread state machines (T, E) feeding program_flow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flow_sequencer
  import flow_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  output logic       cycle,
  output logic [1:0] n,
  output logic [1:0] mux_JC,
  output logic       mux_mem,
  output logic       en_pc,
  output logic       en_ra,
  output logic       en_addr_hi,
  output logic       en_addr_lo,
  output logic       mux_RA,
  output logic       mux_pc_a1,
  output logic       mux_pc_a2,
  output logic       mux_offs,
  output logic       halted_T,
  output logic       halted_E,
  output logic [1:0] db_state_T,
  output logic [1:0] db_state_E
);

  logic    cycle_q, cycle_d;
  b_ctrl_t w_b_t, w_b_e, w_b;
  a_ctrl_t w_a_t, w_a_e, w_a;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_q <= EVEN;
    else       cycle_q <= cycle_d;
  end

  always_comb begin
    cycle_d = ~cycle_q;
  end

  // Thread T owns A when cycle is EVEN, so it owns B when cycle is ODD.
  thread_fsm u_thread_t (
    .clk        (clk),
    .reset      (reset),
    .i_b_active (cycle_q == ODD),
    .i_data     (in_data),
    .o_state    (db_state_T),
    .o_b        (w_b_t),
    .o_a        (w_a_t)
  );

  thread_fsm u_thread_e (
    .clk        (clk),
    .reset      (reset),
    .i_b_active (cycle_q == EVEN),
    .i_data     (in_data),
    .o_state    (db_state_E),
    .o_b        (w_b_e),
    .o_a        (w_a_e)
  );

  assign w_b = (cycle_q == ODD) ? w_b_t : w_b_e;
  assign w_a = (cycle_q == ODD) ? w_a_e : w_a_t;

  assign cycle      = cycle_q;
  assign n          = w_a.n;
  assign mux_JC     = w_a.jc;
  assign mux_mem    = w_a.mem;
  assign en_pc      = w_b.en_pc;
  assign en_ra      = w_b.en_ra;
  assign en_addr_hi = w_b.en_addr_hi;
  assign en_addr_lo = w_b.en_addr_lo;
  assign mux_RA     = w_b.mux_ra;
  assign mux_pc_a1  = w_b.mux_pc_a1;
  assign mux_pc_a2  = w_b.mux_pc_a2;
  assign mux_offs   = w_b.mux_offs;
  assign halted_T   = (db_state_T == ST_HALT);
  assign halted_E   = (db_state_E == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_flow_sequencer.sv
// ============================================================================
// Module   : tb_flow_sequencer
// Purpose  : Directed plus random stimulus for flow_sequencer, checked against
//            an instruction-level model of the two interleaved threads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flow_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       cycle, mux_mem, en_pc, en_ra, en_addr_hi, en_addr_lo;
  logic       mux_RA, mux_pc_a1, mux_pc_a2, mux_offs, halted_T, halted_E;
  logic [1:0] n, mux_JC, db_state_T, db_state_E;
  logic [7:0] obs_b;

  int checks = 0;
  int passed = 0;

  // Model: 0 = waiting first B phase, 1 = expecting opcode, 2 = expecting operand, 3 = halted
  logic [1:0] mode   [2];
  logic [7:0] lat    [2];
  logic [1:0] nx_jc  [2];
  logic       nx_mem [2];
  logic       ph;

  flow_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .cycle      (cycle),
    .n          (n),
    .mux_JC     (mux_JC),
    .mux_mem    (mux_mem),
    .en_pc      (en_pc),
    .en_ra      (en_ra),
    .en_addr_hi (en_addr_hi),
    .en_addr_lo (en_addr_lo),
    .mux_RA     (mux_RA),
    .mux_pc_a1  (mux_pc_a1),
    .mux_pc_a2  (mux_pc_a2),
    .mux_offs   (mux_offs),
    .halted_T   (halted_T),
    .halted_E   (halted_E),
    .db_state_T (db_state_T),
    .db_state_E (db_state_E)
  );

  assign obs_b = {en_pc, en_ra, en_addr_hi, en_addr_lo, mux_RA, mux_pc_a1, mux_pc_a2, mux_offs};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_init();
    ph = 1'b0;
    for (int t = 0; t < 2; t++) begin
      mode[t] = 2'd0; lat[t] = 8'h00; nx_jc[t] = 2'b01; nx_mem[t] = 1'b0;
    end
  endtask

  task automatic check_reset_state();
    chk("rst_cycle",   {7'd0, cycle},     8'h00);
    chk("rst_bstrobe", obs_b,             8'h00);
    chk("rst_mux_JC",  {6'd0, mux_JC},    8'h01);
    chk("rst_mux_mem", {7'd0, mux_mem},   8'h00);
    chk("rst_n",       {6'd0, n},         8'h00);
    chk("rst_halted",  {6'd0, halted_T, halted_E}, 8'h00);
    chk("rst_db",      {4'd0, db_state_T, db_state_E}, 8'h00);
  endtask

  // Called just after a rising edge; asserts reset, checks, releases after next edge.
  task automatic do_reset();
    reset   = 1'b1;
    in_data = 8'($urandom);
    #1;
    check_reset_state();
    @(posedge clk); #1;
    check_reset_state();
    reset = 1'b0;
    model_init();
  endtask

  // One clock with byte d offered to the current B thread.
  task automatic step(input logic [7:0] d);
    int         b, a;
    logic [2:0] op;
    logic [7:0] exp_b;
    logic [1:0] new_mode, new_jc;
    logic [7:0] new_lat;
    logic       new_mem;
    b = ph ? 0 : 1;
    a = ph ? 1 : 0;
    in_data  = d;
    exp_b    = 8'h00;
    new_mode = mode[b];
    new_lat  = lat[b];
    new_jc   = 2'b01;
    new_mem  = 1'b0;
    case (mode[b])
      2'd0: new_mode = 2'd1;
      2'd1: begin
        op = d[7:5];
        if (op >= 3'd6) new_mode = 2'd3;
        else if (op == 3'd0 || op == 3'd5) begin
          exp_b = 8'h80; new_jc = 2'b00; new_mem = (op == 3'd5);
        end else begin
          exp_b = 8'h80; new_lat = d; new_mode = 2'd2;
          if (op == 3'd1 || op == 3'd2) new_jc = 2'b10;
        end
      end
      2'd2: begin
        op = lat[b][7:5];
        new_mode = 2'd1;
        new_jc   = 2'b00;
        if (op == 3'd1 || op == 3'd2) exp_b = {7'b1111001, op == 3'd1};
        else if (op == 3'd3)          exp_b = {7'b1000011, lat[b][4]};
        else begin                    exp_b = {7'b1100100, lat[b][4]}; new_jc = 2'b11; end
      end
      default: ;
    endcase
    @(negedge clk);
    chk("cycle",      {7'd0, cycle},      {7'd0, ph});
    chk("b_strobes",  obs_b,              exp_b);
    chk("mux_JC",     {6'd0, mux_JC},     {6'd0, nx_jc[a]});
    chk("mux_mem",    {7'd0, mux_mem},    {7'd0, nx_mem[a]});
    chk("n",          {6'd0, n},          {6'd0, lat[a][1:0]});
    chk("halted_T",   {7'd0, halted_T},   {7'd0, mode[0] == 2'd3});
    chk("halted_E",   {7'd0, halted_E},   {7'd0, mode[1] == 2'd3});
    chk("db_state_T", {6'd0, db_state_T}, {6'd0, mode[0]});
    chk("db_state_E", {6'd0, db_state_E}, {6'd0, mode[1]});
    @(posedge clk);
    mode[b]   = new_mode;
    lat[b]    = new_lat;
    nx_jc[b]  = new_jc;
    nx_mem[b] = new_mem;
    nx_jc[a]  = 2'b01;
    nx_mem[a] = 1'b0;
    ph        = ~ph;
    #1;
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] r;
    r = 8'($urandom);
    if ($urandom_range(0, 99) < 2) r[7:6] = 2'b11;
    else                           r[7:5] = 3'($urandom_range(0, 5));
    return r;
  endfunction

  initial begin
    reset   = 1'b1;
    in_data = 8'h00;
    model_init();
    @(posedge clk); #1;
    check_reset_state();
    @(posedge clk); #1;
    reset = 1'b0;

    // Start phases, then T NOP / E JST+operand / T CALL n=3 / E WR.
    step(8'h00); step(8'h00);
    step(8'h20); step(8'h00);
    step(8'h3C); step(8'h93);
    step(8'hA0); step(8'h55);
    step(8'h00); step(8'h00);
    step(8'h00); step(8'h00);

    // Mid-instruction reset: E has just latched a BSTK opcode.
    step(8'h70);
    do_reset();

    // T halts while E keeps executing NOPs; then reset clears it.
    step(8'h00); step(8'h00);
    step(8'h00); step(8'hE0);
    for (int i = 0; i < 8; i++) step(8'h00);
    chk("halted_T_set", {7'd0, halted_T}, 8'h01);
    do_reset();

    // Simultaneous HALT in E and CALL in T.
    step(8'h00); step(8'h00);
    step(8'hC0); step(8'h83);
    step(8'h11); step(8'h12);
    step(8'h00); step(8'h00);

    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else                            step(rand_byte());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
